pattern_event_recorder: RTL

Downstream consumer of the sequence detector. Monitors the detector's `pattern` flag, turns each rising edge into a single event, and tags it with a free-running cycle timestamp and the 4-bit `number` present on that cycle. Events go into a small show-ahead FIFO, which a host or debug reader drains. The block also keeps a saturating total-event count and a sticky overflow flag, so dropped events stay visible.

---
 rtl/pattern_event_pkg.sv | 16 +
 rtl/event_fifo.sv | 53 +++++
 rtl/pattern_event_recorder.sv | 70 +++++++
 3 files changed

// File: rtl/pattern_event_pkg.sv
// Shared defaults and entry layout for the pattern event recorder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_event_pkg;

    localparam int DEF_TS_WIDTH  = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_CNT_WIDTH = 8;

    localparam int ENTRY_W = DEF_TS_WIDTH + 4;

    // Entry layout is {timestamp, number}
    localparam int NUM_LSB = 0;
    localparam int TS_LSB  = 4;

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous show-ahead FIFO; head entry is always on dout.
// Latency: a push is visible on dout one edge later; a pop advances dout on the same edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge; pop while empty is ignored.
module event_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A full FIFO can still accept a push when the head leaves on the same edge
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/pattern_event_recorder.sv
// Turns rising edges of the detector's pattern flag into timestamped events queued for a reader.
// Latency: an event sampled at an edge is on rd_data (empty=0) after that same edge.
// Backpressure: none upstream; events arriving while full without a read are dropped and flagged in overflow.
module pattern_event_recorder
    import pattern_event_pkg::*;
#(
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       pattern,
    input  logic [3:0]                 number,
    input  logic                       rd_en,
    output logic [TS_WIDTH+3:0]        rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       total_events
);

    localparam int EW = TS_WIDTH + 4;

    logic                pattern_d;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic                event_hit;
    logic [EW-1:0]       entry;

    assign event_hit = pattern & ~pattern_d;

    always_comb begin
        entry = '0;
        entry[TS_LSB +: TS_WIDTH] = ts_cnt;
        entry[NUM_LSB +: 4]       = number;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pattern_d    <= 1'b0;
            ts_cnt       <= '0;
            overflow     <= 1'b0;
            total_events <= '0;
        end else begin
            pattern_d <= pattern;
            ts_cnt    <= ts_cnt + TS_WIDTH'(1);
            // Only a full FIFO with no simultaneous read loses the event
            if (event_hit && full && !rd_en) overflow <= 1'b1;
            if (event_hit && (total_events != '1))
                total_events <= total_events + CNT_WIDTH'(1);
        end
    end

    event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (event_hit),
        .pop     (rd_en),
        .din     (entry),
        .dout    (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

endmodule
